// File: rtl/cfg_sequencer_pkg.sv
// Shared definitions for the fpga configuration path: byte width, serializer
// fill-count width, and the sequencer state encoding used by cfg_sequencer and
// the tile modules.
package cfg_sequencer_pkg;

    localparam int BYTE_W = 8;
    localparam int FILL_W = 4;   // holds 0..BYTE_W

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ARM,
        ST_STREAM,
        ST_WAIT_READY,
        ST_RUN,
        ST_ERROR
    } seq_state_e;

endpackage

// File: rtl/cfg_sequencer_if.sv
// axi_stream_if: minimal AXI-stream style bundle for the configuration
// bitstream broadcast to all lut tiles.
//   tvalid/tdata/tlast : master -> slave
//   tready             : slave  -> master
// Only tdata[0] carries payload in the configuration path.
interface axi_stream_if #(
    parameter int DATA_W = 1
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/cfg_sequencer_byte_serializer.sv
// byte_serializer: one-byte buffer that turns packed bitstream bytes into
// single-bit beats, LSB first.
//   clk, rst_n   : clock, synchronous active-low reset
//   load_en      : byte intake allowed (sequencer in ARM or STREAM)
//   stream_en    : beats may be presented (sequencer in STREAM)
//   flush        : drop whatever bits remain in the buffer
//   in_valid/in_data/in_ready : byte input handshake
//   bit_valid/bit_data/bit_ready : bit output handshake
module byte_serializer
    import cfg_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              stream_en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_valid,
    output logic              bit_data,
    input  logic              bit_ready
);

    logic [BYTE_W-1:0] shreg;
    logic [FILL_W-1:0] fill;

    // A new byte is taken only once every bit of the previous one is gone,
    // so intake and bit consumption never happen in the same cycle.
    assign in_ready  = load_en && (fill == '0);
    assign bit_valid = stream_en && (fill != '0);
    assign bit_data  = shreg[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            fill  <= '0;
        end else if (flush) begin
            fill  <= '0;
        end else if (in_valid && in_ready) begin
            shreg <= in_data;
            fill  <= FILL_W'(BYTE_W);
        end else if (bit_valid && bit_ready) begin
            shreg <= {1'b0, shreg[BYTE_W-1:1]};
            fill  <= fill - FILL_W'(1);
        end
    end

endmodule

// File: rtl/cfg_sequencer.sv
// cfg_sequencer: configures NUM_TILES lut tiles in turn from a packed byte
// stream. Each tile gets a one-cycle cfg pulse, an idle ARM cycle, then
// BITS_PER_TILE single-bit beats on the broadcast bitstream, then the
// sequencer waits for that tile's cfg_ready (bounded by TIMEOUT_CYCLES).
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin a pass (honoured in IDLE, RUN, ERROR)
//   in_valid/in_data/in_ready : packed bitstream bytes, LSB first
//   cfg[NUM_TILES]      : one-hot configure pulse
//   tile_ready          : per-tile cfg_ready
//   bitstream           : broadcast bit stream (tdata[0], tlast)
//   run / busy / error  : pass complete / pass in progress / timeout
module cfg_sequencer
    import cfg_sequencer_pkg::*;
#(
    parameter int NUM_TILES      = 4,
    parameter int BITS_PER_TILE  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_TILES-1:0] cfg,
    input  logic [NUM_TILES-1:0] tile_ready,
    axi_stream_if.master         bitstream,
    output logic                 run,
    output logic                 busy,
    output logic                 error
);

    localparam int IDX_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int BEAT_W = $clog2(BITS_PER_TILE + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TILES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BITS_PER_TILE - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              flush, beat_done, ser_data;

    assign beat_done = bitstream.tvalid && bitstream.tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            beat     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            beat     <= beat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        beat_nxt  = beat;
        wait_nxt  = wait_cnt;
        flush     = 1'b0;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                // Every pass starts on a byte boundary, so leftovers from an
                // aborted (timed-out) pass are dropped as well.
                if (start) begin
                    state_nxt = ST_SELECT;
                    idx_nxt   = '0;
                    flush     = 1'b1;
                end
            end
            ST_SELECT: begin
                state_nxt = ST_ARM;
                beat_nxt  = '0;
            end
            ST_ARM: state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (beat_done) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt = ST_WAIT_READY;
                        beat_nxt  = '0;
                        wait_nxt  = '0;
                        // Unused tail of the final byte belongs to no tile.
                        flush     = (idx == LAST_IDX);
                    end else begin
                        beat_nxt  = beat + BEAT_W'(1);
                    end
                end
            end
            ST_WAIT_READY: begin
                if (tile_ready[idx]) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_RUN;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ST_SELECT;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = ST_ERROR;
                end else begin
                    wait_nxt  = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cfg   = (state == ST_SELECT) ? (NUM_TILES'(1) << idx) : '0;
    assign run   = (state == ST_RUN);
    // ERROR is left only by start or reset, so the state itself is the sticky flag.
    assign error = (state == ST_ERROR);
    assign busy  = !(state == ST_IDLE || state == ST_RUN || state == ST_ERROR);

    assign bitstream.tlast = (state == ST_STREAM) && (beat == LAST_BEAT);
    always_comb begin
        bitstream.tdata    = '0;
        bitstream.tdata[0] = ser_data;
    end

    byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (state == ST_ARM || state == ST_STREAM),
        .stream_en (state == ST_STREAM),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bit_valid (bitstream.tvalid),
        .bit_data  (ser_data),
        .bit_ready (bitstream.tready)
    );

endmodule

// File: tb/tb_cfg_sequencer.sv
// Bench for cfg_sequencer with 3 tiles of 4 bits (12 bits per pass, so the
// second byte's upper nibble is discarded) and an 8-cycle ready timeout.
// Expected beats come from a bit queue built from the offered bytes.
module tb_cfg_sequencer;

    localparam int NT         = 3;
    localparam int BPT        = 4;
    localparam int TO         = 8;
    localparam int PASS_BITS  = NT * BPT;
    localparam int PASS_BYTES = (PASS_BITS + 7) / 8;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, in_ready, run, busy, error;
    logic [7:0]    in_data;
    logic [NT-1:0] cfg, tile_ready;

    int vectors = 0;
    int miscompares = 0;

    axi_stream_if #(.DATA_W(1)) bs ();

    cfg_sequencer #(.NUM_TILES(NT), .BITS_PER_TILE(BPT), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg        (cfg),
        .tile_ready (tile_ready),
        .bitstream  (bs),
        .run        (run),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        bs.tready = 1'b0; tile_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cfg, bs.tvalid, bs.tlast, in_ready, run, busy, error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got cfg=%b tv=%b tl=%b ir=%b run=%b busy=%b err=%b, want all 0",
                     cfg, bs.tvalid, bs.tlast, in_ready, run, busy, error);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || run !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b run=%b, want 0 0", busy, run);
        end
    endtask

    // One full pass. tmode: 0 tready always 1, 1 toggling 1,0,..., 2 random.
    task automatic run_pass(input int tmode, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0]    src[$];
        bit            exp_bits[$];
        logic [NT-1:0] exp_cfg;
        int            rdy_dly[NT];
        int            beats = 0, pulses = 0, used = 0, cyc = 0, d;
        bit            prev_hold = 0;
        logic          prev_d = 0, prev_l = 0;
        src = '{b0, b1, 8'($urandom)};
        for (int i = 0; i < PASS_BITS; i++) exp_bits.push_back(src[i/8][i%8]);
        for (int t = 0; t < NT; t++) rdy_dly[t] = -1;
        in_valid = 1'b0; tile_ready = '0; bs.tready = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        while (cyc < 400) begin
            if (run) break;
            if (cfg != '0) begin
                exp_cfg = '0;
                if (pulses < NT) exp_cfg[pulses] = 1'b1;
                vectors++;
                if (cfg !== exp_cfg) begin
                    miscompares++;
                    $display("FAIL cfg_pulse: got %b want %b", cfg, exp_cfg);
                end
                pulses++;
            end
            vectors++;
            if (busy !== 1'b1 || error !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_in_pass: busy=%b error=%b want 1 0", busy, error);
            end
            if (prev_hold) begin
                vectors++;
                if (bs.tvalid !== 1'b1 || bs.tdata[0] !== prev_d || bs.tlast !== prev_l) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%b d=%b l=%b want 1 %b %b",
                             bs.tvalid, bs.tdata[0], bs.tlast, prev_d, prev_l);
                end
            end
            if (bs.tvalid) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_while_buffered: got %b want 0", in_ready);
                end
            end
            // drive inputs for the coming edge
            case (tmode)
                0:       bs.tready = 1'b1;
                1:       bs.tready = (cyc % 2 == 0);
                default: bs.tready = 1'($urandom_range(0, 1));
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = (src.size() != 0) ? src[0] : 8'hEE;
            for (int t = 0; t < NT; t++) begin
                if (rdy_dly[t] > 0) begin
                    rdy_dly[t]--;
                    if (rdy_dly[t] == 0) begin tile_ready[t] = 1'b1; rdy_dly[t] = -1; end
                end
            end
            if (bs.tvalid && bs.tready) begin
                vectors++;
                if (beats >= PASS_BITS || bs.tdata[0] !== exp_bits[beats % PASS_BITS]) begin
                    miscompares++;
                    $display("FAIL beat_data[%0d]: got %b want %b", beats, bs.tdata[0],
                             exp_bits[beats % PASS_BITS]);
                end
                vectors++;
                if (bs.tlast !== ((beats % BPT) == BPT - 1)) begin
                    miscompares++;
                    $display("FAIL beat_last[%0d]: got %b want %b", beats, bs.tlast,
                             (beats % BPT) == BPT - 1);
                end
                if ((beats % BPT) == BPT - 1 && beats < PASS_BITS) begin
                    // delay 0 raises ready before WAIT_READY is even entered
                    d = $urandom_range(0, 3);
                    if (d == 0) tile_ready[beats / BPT] = 1'b1;
                    else        rdy_dly[beats / BPT] = d;
                end
                beats++;
            end
            if (in_valid && in_ready) begin
                used++;
                if (src.size() != 0) void'(src.pop_front());
            end
            prev_hold = bs.tvalid && !bs.tready;
            prev_d    = bs.tdata[0];
            prev_l    = bs.tlast;
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (run !== 1'b1) begin miscompares++; $display("FAIL run_after_pass: got %b want 1", run); end
        vectors++;
        if (beats != PASS_BITS) begin miscompares++; $display("FAIL beat_count: got %0d want %0d", beats, PASS_BITS); end
        vectors++;
        if (pulses != NT) begin miscompares++; $display("FAIL cfg_pulse_count: got %0d want %0d", pulses, NT); end
        vectors++;
        if (used != PASS_BYTES) begin miscompares++; $display("FAIL bytes_used: got %0d want %0d", used, PASS_BYTES); end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || run !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL run_hold: in_ready=%b run=%b busy=%b want 0 1 0", in_ready, run, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_pass(0, 8'hA5, 8'hA5);
    endtask

    task automatic test_tready_toggle();
        run_pass(1, 8'hA5, 8'hA5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) run_pass(2, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_timeout();
        int  n = 0;
        bit  hit = 0;
        tile_ready = '0; in_valid = 1'b1; in_data = 8'($urandom); bs.tready = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bs.tvalid && bs.tready && bs.tlast) begin hit = 1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL timeout_reach_last: got 0 want 1"); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (error) break;
            n++;
        end
        vectors++;
        if (n != TO) begin miscompares++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
        repeat (2) @(negedge clk);
        vectors++;
        if (error !== 1'b1 || run !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL error_state: err=%b run=%b busy=%b ir=%b want 1 0 0 0", error, run, busy, in_ready);
        end
        in_valid = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        vectors++;
        if (cfg !== NT'(1) || error !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_from_error: cfg=%b err=%b want %b 0", cfg, error, NT'(1));
        end
    endtask

    task automatic test_reset_mid_stream();
        int seen = 0;
        bit hit = 0;
        in_valid = 1'b1; in_data = 8'h3C; bs.tready = 1'b0; tile_ready = '0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bs.tready = 1'b0;
            if (bs.tvalid) begin
                if (seen == 1) begin hit = 1; break; end
                bs.tready = 1'b1;
                seen++;
            end
            @(negedge clk);
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_mid_reach_beat2: got 0 want 1"); end
        rst_n = 1'b0; in_valid = 1'b0; bs.tready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cfg, bs.tvalid, bs.tlast, in_ready, run, busy, error} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b want 0",
                     {cfg, bs.tvalid, bs.tlast, in_ready, run, busy, error});
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(2, 8'h0F, 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tready_toggle();
        test_back_to_back();
        test_timeout();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
